// File: rtl/dma_rd_master_if.sv
// Command, Avalon-MM read and output stream signals of the DMA read master.
`timescale 1ns/1ps
interface dma_rd_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 5,
  parameter int unsigned LW = 16
);
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [BW-1:0] avm_burstcount;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          busy;
  logic          done;

  modport master (
    input  cmd_addr, cmd_len, cmd_valid, avm_waitrequest, avm_readdata,
           avm_readdatavalid, s_ready,
    output cmd_ready, avm_address, avm_read, avm_burstcount, s_data, s_valid,
           busy, done
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_valid, avm_waitrequest, avm_readdata,
           avm_readdatavalid, s_ready,
    input  cmd_ready, avm_address, avm_read, avm_burstcount, s_data, s_valid,
           busy, done
  );
endinterface

// File: rtl/dma_rd_master.sv
// Avalon-MM burst read master: splits (addr, len) commands into credit-gated bursts.
// Define DMA_RD_BOUNDARY_EN to keep bursts inside MAXB*DW/8-byte aligned windows.
`timescale 1ns/1ps
module dma_rd_master #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned BW     = 5,
  parameter int unsigned LW     = 16,
  parameter int unsigned CREDIT = 32
) (
  input logic               clk,
  input logic               clr,
  dma_rd_master_if.master   bus
);
  localparam int unsigned MAXB = 1 << (BW - 1);
  localparam int unsigned BSH  = $clog2(DW / 8);
  localparam int unsigned PW   = $clog2(CREDIT);
  localparam int unsigned CW   = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [CW-1:0] reserved_q, reserved_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          avm_read_q, avm_read_d;
  logic [AW-1:0] avm_address_q, avm_address_d;
  logic [BW-1:0] avm_burstcount_q, avm_burstcount_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [BW-1:0] lim_c, n_c;
  logic          accept, issue_fire, pop, pop_cr;

  logic [DW-1:0] mem_q [CREDIT];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] mem_cnt_q;
  logic [DW-1:0] s_data_q, s_data_d;
  logic          s_valid_q, s_valid_d;
  logic          out_take, mem_empty, mem_wr, mem_rd;

  assign accept     = bus.cmd_valid && cmd_ready_q;
  assign issue_fire = avm_read_q && !bus.avm_waitrequest;
  assign pop        = s_valid_q && bus.s_ready;
  assign pop_cr     = pop && (reserved_q != '0);

  // Next command state: address/remaining walk and beat reservation.
  always_comb begin : next_state
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    reserved_d = reserved_q + (issue_fire ? CW'(avm_burstcount_q) : CW'(0)) - CW'(pop_cr);
    unique case (state_q)
      IDLE: if (accept) begin
        addr_d  = bus.cmd_addr;
        rem_d   = bus.cmd_len;
        state_d = (bus.cmd_len != '0) ? ISSUE : DRAIN;
      end
      ISSUE: if (issue_fire) begin
        addr_d = addr_q + (AW'(avm_burstcount_q) << BSH);
        rem_d  = rem_q - LW'(avm_burstcount_q);
        if (rem_d == '0) state_d = DRAIN;
      end
      DRAIN: if (reserved_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DMA_RD_BOUNDARY_EN
  assign lim_c = BW'(MAXB) - BW'(addr_d[BSH +: BW-1]);
`else
  assign lim_c = BW'(MAXB);
`endif
  assign n_c = (rem_d < LW'(lim_c)) ? BW'(rem_d) : lim_c;

  // Outputs are computed from next-cycle state so that they can be registered.
  always_comb begin : next_out
    cmd_ready_d      = (state_d == IDLE);
    busy_d           = (state_d != IDLE);
    done_d           = (state_d == DRAIN) && (reserved_d == '0);
    avm_read_d       = (state_d == ISSUE) && ((CW'(CREDIT) - reserved_d) >= CW'(n_c));
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    if (state_d == ISSUE) begin
      avm_address_d    = addr_d;
      avm_burstcount_d = n_c;
    end
  end

  // Read-data buffer with a registered head; an empty buffer passes a beat straight to the head.
  always_comb begin : data_path
    out_take  = !s_valid_q || pop;
    mem_empty = (mem_cnt_q == '0);
    mem_rd    = out_take && !mem_empty;
    mem_wr    = bus.avm_readdatavalid && !(out_take && mem_empty);
    s_valid_d = s_valid_q && !pop;
    s_data_d  = s_data_q;
    if (mem_rd) begin
      s_valid_d = 1'b1;
      s_data_d  = mem_q[rd_ptr_q];
    end else if (out_take && bus.avm_readdatavalid) begin
      s_valid_d = 1'b1;
      s_data_d  = bus.avm_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[wr_ptr_q] <= bus.avm_readdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      rem_q            <= '0;
      reserved_q       <= '0;
      cmd_ready_q      <= 1'b1;
      avm_read_q       <= 1'b0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      mem_cnt_q        <= '0;
      s_valid_q        <= 1'b0;
      s_data_q         <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      rem_q            <= rem_d;
      reserved_q       <= reserved_d;
      cmd_ready_q      <= cmd_ready_d;
      avm_read_q       <= avm_read_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      if (mem_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (mem_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      mem_cnt_q        <= mem_cnt_q + CW'(mem_wr) - CW'(mem_rd);
      s_valid_q        <= s_valid_d;
      s_data_q         <= s_data_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_burstcount = avm_burstcount_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.s_valid        = s_valid_q;
  assign bus.s_data         = s_data_q;
endmodule

// File: tb/tb_dma_rd_master.sv
// Directed and randomized checks of dma_rd_master against a burst/data reference model.
`timescale 1ns/1ps
module tb_dma_rd_master;
  localparam int MAXB   = 16;
  localparam int CREDIT = 32;

  logic clk, clr;
  int   cyc = 0;
  int unsigned total = 0, bad = 0;

  dma_rd_master_if #(.AW(32), .DW(32), .BW(5), .LW(16)) bus ();
  dma_rd_master #(.AW(32), .DW(32), .BW(5), .LW(16), .CREDIT(CREDIT)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  // Bus-functional environment state, shared with the main sequence.
  int sready_mode = 0, wr_mode = 0, rd_mode = 0, pop_budget = 0;
  int hold_idx = 1, hold_left = 0, bidx = 0;
  int issued = 0, popped = 0, max_res = 0, stab_err = 0;
  int last_pop = -1, first_pop = -1, first_rdv = -1, first_sv = -1;
  bit presenting = 0, prev_stall = 0, prev_done = 0;
  logic [31:0] p_addr;
  logic [4:0]  p_n;
  logic ready_during, ready_after;
  int got_first[$], got_acc[$], got_n[$], done_cyc[$];
  logic [31:0] got_addr[$], got_data[$], rq[$];
  logic [31:0] exp_addr[$];
  int exp_n[$];
  logic [31:0] cmd_a;
  int cmd_l, acc_cyc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5EED_1234;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Avalon slave, stream sink and monitor, evaluated once per cycle after the edge.
  initial begin : bfm
    bit wait_now, sr;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    bus.s_ready           = 1'b0;
    forever begin
      tick();
      if (rq.size() > 0 && (rd_mode == 0 || $urandom_range(3) != 0)) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = word(rq.pop_front());
        if (first_rdv < 0) first_rdv = cyc;
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = $urandom;
      end
      wait_now = 1'b0;
      if (bus.avm_read) begin
        if (wr_mode == 1) wait_now = ($urandom_range(2) == 0);
        else if (wr_mode == 2 && bidx == hold_idx && hold_left > 0) begin
          wait_now = 1'b1;
          hold_left--;
        end
      end
      bus.avm_waitrequest = wait_now;
      if (prev_stall && !(bus.avm_read && bus.avm_address == p_addr && bus.avm_burstcount == p_n))
        stab_err++;
      prev_stall = bus.avm_read && wait_now;
      p_addr = bus.avm_address;
      p_n    = bus.avm_burstcount;
      if (bus.avm_read && !presenting) begin
        got_first.push_back(cyc);
        presenting = 1'b1;
      end
      if (bus.avm_read && !wait_now) begin
        got_addr.push_back(bus.avm_address);
        got_n.push_back(int'(bus.avm_burstcount));
        got_acc.push_back(cyc);
        for (int i = 0; i < int'(bus.avm_burstcount); i++) rq.push_back(bus.avm_address + 32'(4 * i));
        issued += int'(bus.avm_burstcount);
        bidx++;
        presenting = 1'b0;
      end
      case (sready_mode)
        1:       sr = 1'b1;
        2:       sr = ($urandom_range(1) == 1);
        3:       sr = (pop_budget > 0);
        default: sr = 1'b0;
      endcase
      bus.s_ready = sr;
      if (bus.s_valid && first_sv < 0) first_sv = cyc;
      if (bus.s_valid && sr) begin
        got_data.push_back(bus.s_data);
        popped++;
        last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
        if (sready_mode == 3) pop_budget--;
      end
      if (issued - popped > max_res) max_res = issued - popped;
      if (prev_done) ready_after = bus.cmd_ready;
      if (bus.done) begin
        done_cyc.push_back(cyc);
        ready_during = bus.cmd_ready;
      end
      prev_done = bus.done;
    end
  end

  // Reference burst list derived from the splitting rules.
  task automatic build_model(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int r, lim, n;
    exp_addr.delete(); exp_n.delete();
    a = a0; r = len;
    while (r > 0) begin
      lim = MAXB;
`ifdef DMA_RD_BOUNDARY_EN
      lim = MAXB - int'((a / 4) % MAXB);
`endif
      n = (r < lim) ? r : lim;
      exp_addr.push_back(a);
      exp_n.push_back(n);
      a = a + 32'(n * 4);
      r -= n;
    end
  endtask

  task automatic start_cmd(input string tag, input logic [31:0] a, input int len);
    int n;
    got_first.delete(); got_acc.delete(); got_n.delete(); got_addr.delete();
    got_data.delete(); done_cyc.delete();
    issued = 0; popped = 0; max_res = 0; bidx = 0;
    last_pop = -1; first_pop = -1; first_rdv = -1; first_sv = -1;
    ready_during = 1'bx; ready_after = 1'bx;
    cmd_a = a; cmd_l = len;
    build_model(a, len);
    bus.cmd_addr  = a;
    bus.cmd_len   = 16'(len);
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin tick(); n++; end
    chk({tag, ".cmd_ready"}, bus.cmd_ready, 1);
    acc_cyc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    chk({tag, ".busy"}, bus.busy, 1);
  endtask

  task automatic finish_cmd(input string tag);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < 3000) begin tick(); n++; end
    repeat (3) tick();
    chk({tag, ".done_count"}, done_cyc.size(), 1);
    chk({tag, ".nbursts"}, got_n.size(), exp_n.size());
    for (int i = 0; i < exp_n.size() && i < got_n.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), got_addr[i], exp_addr[i]);
      chk($sformatf("%s.n%0d", tag, i), got_n[i], exp_n[i]);
    end
    chk({tag, ".nbeats"}, got_data.size(), cmd_l);
    for (int i = 0; i < cmd_l && i < got_data.size(); i++)
      chk($sformatf("%s.data%0d", tag, i), got_data[i], word(cmd_a + 32'(4 * i)));
    if (done_cyc.size() > 0) begin
      if (cmd_l != 0) begin
        chk({tag, ".done_at"}, done_cyc[0], last_pop + 1);
        if (got_first.size() > 0) chk({tag, ".first_read"}, got_first[0], acc_cyc + 1);
        chk({tag, ".sv_latency"}, first_sv, first_rdv + 1);
      end else begin
        chk({tag, ".done_at"}, done_cyc[0], acc_cyc + 1);
      end
    end
    chk({tag, ".ready_during_done"}, ready_during, 0);
    chk({tag, ".ready_after_done"}, ready_after, 1);
    chk({tag, ".credit"}, (max_res <= CREDIT), 1);
    chk({tag, ".wait_stable"}, stab_err, 0);
  endtask

  initial begin : main
    int n;
    logic [31:0] a;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    clr = 1'b1;
    repeat (3) tick();
    chk("rst.cmd_ready", bus.cmd_ready, 1);
    chk("rst.avm_read", bus.avm_read, 0);
    chk("rst.avm_address", bus.avm_address, 0);
    chk("rst.avm_burstcount", bus.avm_burstcount, 0);
    chk("rst.s_valid", bus.s_valid, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    clr = 1'b0;
    tick();

    // Aligned command, streaming sink.
    sready_mode = 1; wr_mode = 0; rd_mode = 0;
    start_cmd("al", 32'h1000, 40);
    finish_cmd("al");
    chk("al.nb3", got_n.size(), 3);
    if (got_first.size() > 1 && got_acc.size() > 0) chk("al.b2b", got_first[1], got_acc[0] + 1);
    chk("al.tput", last_pop - first_pop, 39);

    // Boundary split.
    start_cmd("bnd", 32'h1038, 20);
    finish_cmd("bnd");
`ifdef DMA_RD_BOUNDARY_EN
    chk("bnd.nb", got_n.size(), 3);
`else
    chk("bnd.nb", got_n.size(), 2);
`endif

    // Credit stall.
    sready_mode = 0;
    start_cmd("stall", 32'h4000, 64);
    repeat (60) tick();
    chk("stall.issued", issued, 32);
    chk("stall.read_low", bus.avm_read, 0);
    chk("stall.max_res", max_res, 32);
    chk("stall.no_pop", got_data.size(), 0);
    sready_mode = 1;
    finish_cmd("stall");

    // Waitrequest hold on the second burst.
    wr_mode = 2; hold_idx = 1; hold_left = 5;
    start_cmd("hold", 32'h3000, 48);
    finish_cmd("hold");
    if (got_acc.size() > 1 && got_first.size() > 1) chk("hold.len", got_acc[1] - got_first[1], 5);
    wr_mode = 0;

    // Zero-length command.
    start_cmd("len0", 32'h5000, 0);
    finish_cmd("len0");

    // Reset mid-transfer with nothing outstanding on the fabric.
    sready_mode = 0;
    start_cmd("mid", 32'h1000, 40);
    repeat (40) tick();
    pop_budget = 10; sready_mode = 3;
    n = 0;
    while (popped < 10 && n < 200) begin tick(); n++; end
    repeat (30) tick();
    n = 0;
    while (rq.size() != 0 && n < 200) begin tick(); n++; end
    chk("mid.beats10", got_data.size(), 10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("mid.cmd_ready", bus.cmd_ready, 1);
    chk("mid.avm_read", bus.avm_read, 0);
    chk("mid.avm_address", bus.avm_address, 0);
    chk("mid.avm_burstcount", bus.avm_burstcount, 0);
    chk("mid.s_valid", bus.s_valid, 0);
    chk("mid.busy", bus.busy, 0);
    chk("mid.done", bus.done, 0);
    sready_mode = 1;
    repeat (2) tick();
    start_cmd("post", 32'h2000, 4);
    finish_cmd("post");

    // Randomized commands, sink back-pressure, waitrequest and data gaps.
    for (int k = 0; k < 10; k++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if (k % 3 == 0) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 63) * 4);
      sready_mode = $urandom_range(1, 2);
      wr_mode     = $urandom_range(0, 1);
      rd_mode     = $urandom_range(0, 1);
      start_cmd($sformatf("rnd%0d", k), a, $urandom_range(0, 90));
      finish_cmd($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
